serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter_pkg.sv | 14 +
 rtl/add2_slice.sv | 35 +++
 rtl/serial_add_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_serial_add_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_arbiter_pkg.sv
// Shared types and constants for the two-requester serial adder.
package serial_add_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ID_A    = 1'b0;
    localparam logic ID_B    = 1'b1;
    localparam int   SLICE_W = 2;

endpackage

// File: rtl/add2_slice.sv
// Registered 2-bit full-adder slice; both sum and carry-out are flopped.
module add2_slice
    import serial_add_arbiter_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0]   sum_d;
    logic [SLICE_W-1:0] s_q;
    logic               co_q;

    always_comb begin
        sum_d = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, ci};
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            s_q  <= sum_d[SLICE_W-1:0];
            co_q <= sum_d[SLICE_W];
        end
    end

    assign s  = s_q;
    assign co = co_q;

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter sharing one registered 2-bit adder slice between two requesters.
// Define SERIAL_ADD_ARBITER_OVF_EN to add the signed-overflow output res_ovf.
module serial_add_arbiter
    import serial_add_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             a_valid,
    input  logic             b_valid,
    output logic             a_ready,
    output logic             b_ready,
    input  logic [WIDTH-1:0] a_opx,
    input  logic [WIDTH-1:0] a_opy,
    input  logic [WIDTH-1:0] b_opx,
    input  logic [WIDTH-1:0] b_opy,
    input  logic             a_cin,
    input  logic             b_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
`ifdef SERIAL_ADD_ARBITER_OVF_EN
    output logic             res_ovf,
`endif
    output logic             res_id
);

    localparam int HALF  = WIDTH / SLICE_W;
    localparam int CNT_W = $clog2(HALF + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prio_q, prio_d;
    logic [WIDTH-1:0]   opx_q, opx_d;
    logic [WIDTH-1:0]   opy_q, opy_d;
    logic               cin_q, cin_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_sum_q, res_sum_d;
    logic               res_cout_q, res_cout_d;
    logic               res_id_q, res_id_d;
    logic               grant_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               slice_ci;
    int                 lane;
`ifdef SERIAL_ADD_ARBITER_OVF_EN
    logic               msb_x_q, msb_x_d;
    logic               msb_y_q, msb_y_d;
    logic               res_ovf_q, res_ovf_d;
`endif

    // Operands shift down one slice per RUN cycle, so the slice always sees the low pair.
    assign slice_ci = (cnt_q == '0) ? cin_q : slice_co;

    add2_slice u_slice (
        .Clock (Clock),
        .Reset (Reset),
        .x     (opx_q[SLICE_W-1:0]),
        .y     (opy_q[SLICE_W-1:0]),
        .ci    (slice_ci),
        .s     (slice_s),
        .co    (slice_co)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        opx_d       = opx_q;
        opy_d       = opy_q;
        cin_d       = cin_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_id_d    = res_id_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        grant_b     = 1'b0;
        lane        = int'(cnt_q) - 1;
`ifdef SERIAL_ADD_ARBITER_OVF_EN
        msb_x_d     = msb_x_q;
        msb_y_d     = msb_y_q;
        res_ovf_d   = res_ovf_q;
`endif
        case (state_q)
            IDLE: begin
                grant_b = b_valid && (!a_valid || (prio_q == ID_B));
                if (a_valid || b_valid) begin
                    a_ready  = !grant_b;
                    b_ready  = grant_b;
                    opx_d    = grant_b ? b_opx : a_opx;
                    opy_d    = grant_b ? b_opy : a_opy;
                    cin_d    = grant_b ? b_cin : a_cin;
                    res_id_d = grant_b ? ID_B : ID_A;
                    prio_d   = grant_b ? ID_A : ID_B;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef SERIAL_ADD_ARBITER_OVF_EN
                    msb_x_d  = grant_b ? b_opx[WIDTH-1] : a_opx[WIDTH-1];
                    msb_y_d  = grant_b ? b_opy[WIDTH-1] : a_opy[WIDTH-1];
`endif
                end
            end
            RUN: begin
                opx_d = opx_q >> SLICE_W;
                opy_d = opy_q >> SLICE_W;
                // The slice output lags its issue by one cycle, so count k lands lane k-1.
                if (cnt_q != '0) begin
                    res_sum_d[SLICE_W*lane +: SLICE_W] = slice_s;
                end
                if (cnt_q == CNT_W'(HALF)) begin
                    res_valid_d = 1'b1;
                    res_cout_d  = slice_co;
                    state_d     = DONE;
`ifdef SERIAL_ADD_ARBITER_OVF_EN
                    res_ovf_d   = (msb_x_q == msb_y_q) && (slice_s[SLICE_W-1] != msb_x_q);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!Reset) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prio_q      <= ID_A;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_id_q    <= res_id_d;
        end
    end

    // Latched operands are pure data and need no reset.
    always_ff @(posedge Clock) begin
        opx_q <= opx_d;
        opy_q <= opy_d;
        cin_q <= cin_d;
    end

`ifdef SERIAL_ADD_ARBITER_OVF_EN
    always_ff @(posedge Clock) begin
        msb_x_q <= msb_x_d;
        msb_y_q <= msb_y_d;
        if (!Reset) begin
            res_ovf_q <= 1'b0;
        end else begin
            res_ovf_q <= res_ovf_d;
        end
    end

    assign res_ovf = res_ovf_q;
`endif

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter (WIDTH=16); overflow checks only when SERIAL_ADD_ARBITER_OVF_EN is defined.
module tb_serial_add_arbiter;

    localparam int W = 16;

    logic         Clock;
    logic         Reset;
    logic         a_valid, b_valid;
    logic         a_ready, b_ready;
    logic [W-1:0] a_opx, a_opy, b_opx, b_opy;
    logic         a_cin, b_cin;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id;
`ifdef SERIAL_ADD_ARBITER_OVF_EN
    logic         res_ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .a_opx     (a_opx),
        .a_opy     (a_opy),
        .b_opx     (b_opx),
        .b_opy     (b_opy),
        .a_cin     (a_cin),
        .b_cin     (b_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
`ifdef SERIAL_ADD_ARBITER_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .res_id    (res_id)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Raise one request, wait for its grant, then scramble the inputs after accept.
    task automatic issue(input logic use_b, input logic [W-1:0] x, input logic [W-1:0] y, input logic cin);
        int n;
        if (use_b) begin
            b_valid = 1'b1; b_opx = x; b_opy = y; b_cin = cin;
        end else begin
            a_valid = 1'b1; a_opx = x; a_opy = y; a_cin = cin;
        end
        #1;
        n = 0;
        while (!(use_b ? b_ready : a_ready) && n < 30) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("grant", use_b ? b_ready : a_ready, 1);
        @(posedge Clock); #1;
        chk("ready_one_cycle", use_b ? b_ready : a_ready, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        a_opx = ~x; a_opy = ~y; a_cin = ~cin;
        b_opx = ~x; b_opy = ~y; b_cin = ~cin;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge Clock); #1;
            lat++;
            if (res_valid) break;
        end
        chk("res_valid_seen", res_valid, 1);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(posedge Clock); #1;
        res_ready = 1'b0;
        chk("res_valid_clear", res_valid, 0);
    endtask

    initial begin
        int lat;
        int n;
        logic seen;
        logic [W-1:0] held;

        Reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        a_opx = '0; a_opy = '0; b_opx = '0; b_opy = '0; a_cin = 1'b0; b_cin = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_id", res_id, 0);
        Reset = 1'b1;
        @(posedge Clock); #1;

        // A only, latency and sum
        issue(1'b0, 16'h1234, 16'h4321, 1'b0);
        wait_result(lat);
        chk("a_latency", lat, 9);
        chk("a_sum", res_sum, 16'h5555);
        chk("a_cout", res_cout, 0);
        chk("a_id", res_id, 0);
        drain();

        // A with carry-in rippling through every slice
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b1);
        wait_result(lat);
        chk("cin_sum", res_sum, 16'h0000);
        chk("cin_cout", res_cout, 1);
        drain();

        // B only, full carry ripple
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        wait_result(lat);
        chk("b_latency", lat, 9);
        chk("b_sum", res_sum, 16'h0000);
        chk("b_cout", res_cout, 1);
        chk("b_id", res_id, 1);
        drain();

        // Both requesting continuously: grants alternate starting with A
        a_opx = 16'h1111; a_opy = 16'h2222; a_cin = 1'b0;
        b_opx = 16'h0F0F; b_opy = 16'h00F1; b_cin = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(a_ready || b_ready) && n < 20) begin
                @(posedge Clock); #1;
                n++;
            end
            chk("alt_grant_any", a_ready | b_ready, 1);
            chk("alt_grant_b", b_ready, i % 2);
            @(posedge Clock); #1;
            seen = 1'b0;
            lat = 0;
            while (!res_valid && lat < 40) begin
                @(posedge Clock); #1;
                lat++;
                if (a_ready || b_ready) seen = 1'b1;
            end
            chk("alt_no_ready_busy", seen, 0);
            chk("alt_id", res_id, i % 2);
            chk("alt_sum", res_sum, (i % 2) ? 16'h1001 : 16'h3333);
            chk("alt_cout", res_cout, 0);
            @(posedge Clock); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        @(posedge Clock); #1;

        // Stall in DONE with B waiting
        issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
        wait_result(lat);
        held = res_sum;
        b_valid = 1'b1; b_opx = 16'h0001; b_opy = 16'h0002; b_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            chk("stall_valid", res_valid, 1);
            chk("stall_sum", res_sum, 16'h0100);
            chk("stall_id", res_id, 0);
            chk("stall_b_ready", b_ready, 0);
        end
        chk("stall_sum_held", res_sum, held);
        res_ready = 1'b1;
        #1;
        chk("handshake_no_grant", b_ready, 0);
        @(posedge Clock); #1;
        res_ready = 1'b0;
        chk("post_stall_valid", res_valid, 0);
        chk("post_stall_grant_b", b_ready, 1);
        @(posedge Clock); #1;
        b_valid = 1'b0; b_opx = 16'hAAAA; b_opy = 16'h5555;
        wait_result(lat);
        chk("post_stall_sum", res_sum, 16'h0003);
        chk("post_stall_id", res_id, 1);
        drain();

        // Reset during RUN cycle 3 aborts the operation
        issue(1'b0, 16'h1234, 16'h1111, 1'b0);
        repeat (3) begin
            @(posedge Clock); #1;
        end
        Reset = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        @(posedge Clock); #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_sum", res_sum, 0);
        chk("abort_res_cout", res_cout, 0);
        chk("abort_res_id", res_id, 0);
        chk("abort_a_ready", a_ready, 0);
        chk("abort_b_ready", b_ready, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        Reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge Clock); #1;
            if (res_valid) seen = 1'b1;
        end
        chk("abort_no_stale_valid", seen, 0);
        a_opx = 16'h0101; a_opy = 16'h0202; a_cin = 1'b0;
        b_opx = 16'h7777; b_opy = 16'h1111; b_cin = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("after_rst_grant_a", a_ready, 1);
        chk("after_rst_not_b", b_ready, 0);
        @(posedge Clock); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_result(lat);
        chk("after_rst_sum", res_sum, 16'h0303);
        chk("after_rst_id", res_id, 0);
        drain();

`ifdef SERIAL_ADD_ARBITER_OVF_EN
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_result(lat);
        chk("ovf_pos_sum", res_sum, 16'h8000);
        chk("ovf_pos", res_ovf, 1);
        chk("ovf_pos_cout", res_cout, 0);
        drain();
        issue(1'b1, 16'h8000, 16'hFFFF, 1'b0);
        wait_result(lat);
        chk("ovf_neg_sum", res_sum, 16'h7FFF);
        chk("ovf_neg", res_ovf, 1);
        chk("ovf_neg_cout", res_cout, 1);
        drain();
        issue(1'b0, 16'h0001, 16'h0001, 1'b0);
        wait_result(lat);
        chk("ovf_none_sum", res_sum, 16'h0002);
        chk("ovf_none", res_ovf, 0);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
